multicore_dmem_arbiter: RTL and testbench

MULTICORE_DMEM_ARBITER -- requirements
Module: multicore_dmem_arbiter

---
 rtl/multicore_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/multicore_dmem_arbiter.sv | 133 +++++++++++++
 tb/tb_multicore_dmem_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicore_pkg.sv
// Shared types and default sizing for the multicore data-memory arbiter.
// Declarations only: no logic, no latency, no flow control.
package multicore_pkg;

  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: searches upward from last_grant+1 (mod NUM_CORES); combinational, 0 latency.
// No backpressure: valid simply reports whether any request bit is set.
module rr_arbiter
  import multicore_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  localparam int IDX_W    = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [IDX_W-1:0]     winner,
  output logic                 valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    winner = last_grant;
    valid  = 1'b0;
    cand   = '0;
    // Offset NUM_CORES wraps back to last_grant itself, so a lone requester always wins.
    for (int i = 1; i <= NUM_CORES; i++) begin
      cand = IDX_W'((int'(last_grant) + i) % NUM_CORES);
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/multicore_dmem_arbiter.sv
// Shares one data memory among NUM_CORES cores: one access per 3 cycles, ack two cycles after grant.
// Cores hold requests until their ack pulse; losers simply wait (no timeout, round-robin fairness).
module multicore_dmem_arbiter
  import multicore_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                        clk,
  input  logic                        RESET,
  input  logic                        START,
  input  logic [NUM_CORES-1:0]        core_read,
  input  logic [NUM_CORES-1:0]        core_write,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  input  logic [NUM_CORES-1:0]        core_end,
  output logic [NUM_CORES-1:0]        core_ack,
  output logic [NUM_CORES*DATA_W-1:0] core_rdata,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        END,
  output logic                        protocol_err
);

  localparam int IDX_W = $clog2(NUM_CORES);

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     winner;
  logic [IDX_W-1:0]     rr_winner;
  logic                 rr_valid;
  logic                 op_write;
  logic [NUM_CORES-1:0] req_any;
  logic [NUM_CORES-1:0] end_flags;

  assign req_any = core_read | core_write;

  rr_arbiter #(
    .NUM_CORES (NUM_CORES)
  ) u_rr (
    .req        (req_any),
    .last_grant (last_grant),
    .winner     (rr_winner),
    .valid      (rr_valid)
  );

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Strobes and ack decode straight from state so reset clears them immediately.
  always_comb begin
    state_nxt = state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    core_ack  = '0;
    case (state)
      IDLE: begin
        if (rr_valid) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mem_write = op_write;
        mem_read  = !op_write;
        state_nxt = ACK;
      end
      ACK: begin
        core_ack[winner] = 1'b1;
        state_nxt        = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Access is captured once at grant; later request changes cannot disturb it.
  // A core raising read and write together is treated as a write.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      winner     <= '0;
      op_write   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      last_grant <= IDX_W'(NUM_CORES - 1);
    end else begin
      if (state == IDLE && rr_valid) begin
        winner    <= rr_winner;
        op_write  <= core_write[rr_winner];
        mem_addr  <= core_addr[rr_winner*ADDR_W +: ADDR_W];
        mem_wdata <= core_wdata[rr_winner*DATA_W +: DATA_W];
      end
      if (state == ACK) begin
        last_grant <= winner;
      end
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      core_rdata <= '0;
    end else if (state == ACK && !op_write) begin
      core_rdata[winner*DATA_W +: DATA_W] <= mem_rdata;
    end
  end

  // START takes priority over same-cycle end or protocol events.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      end_flags    <= '0;
      END          <= 1'b0;
      protocol_err <= 1'b0;
    end else if (START) begin
      end_flags    <= '0;
      END          <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      end_flags    <= end_flags | core_end;
      END          <= &(end_flags | core_end);
      protocol_err <= protocol_err | (|(core_read & core_write));
    end
  end

endmodule

// File: tb/tb_multicore_dmem_arbiter.sv
// Bench for multicore_dmem_arbiter: transaction-level reference model, per-cycle compare, directed scenarios.
module tb_multicore_dmem_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              RESET = 1'b1;
  logic              START = 1'b0;
  logic [N-1:0]      core_read, core_write, core_end, core_ack;
  logic [N*AW-1:0]   core_addr;
  logic [N*DW-1:0]   core_wdata, core_rdata;
  logic              mem_read, mem_write, END, protocol_err;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata = '0;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  always #5 clk = ~clk;

  multicore_dmem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .RESET        (RESET),
    .START        (START),
    .core_read    (core_read),
    .core_write   (core_write),
    .core_addr    (core_addr),
    .core_wdata   (core_wdata),
    .core_end     (core_end),
    .core_ack     (core_ack),
    .core_rdata   (core_rdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .END          (END),
    .protocol_err (protocol_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory environment: read data appears the cycle after mem_read.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem[mem_addr[7:0]];
  end

  // Reference model: an access granted at edge g strobes memory in cycle g, acks in cycle g+1,
  // completes at edge g+2 and lets the next grant happen at edge g+3.
  int            edge_n = 0;
  bit            m_busy;
  int            m_gedge, m_core, m_last, c;
  bit            m_wr, found;
  logic [AW-1:0] m_addr, m_addr_out;
  logic [DW-1:0] m_data, m_wdata_out;
  logic [DW-1:0] m_rdata [N];
  logic [N-1:0]  m_endseen;
  bit            m_perr;
  logic [DW-1:0] mm [256];

  always @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      m_busy = 0; m_gedge = -10; m_core = 0; m_last = N - 1; m_wr = 0;
      m_addr = '0; m_data = '0; m_addr_out = '0; m_wdata_out = '0;
      m_endseen = '0; m_perr = 0;
      for (int k = 0; k < N; k++) m_rdata[k] = '0;
    end else begin
      edge_n++;
      if (m_busy && edge_n == m_gedge + 2) begin
        if (!m_wr) m_rdata[m_core] = mm[m_addr[7:0]];
        m_last = m_core;
      end
      if (m_busy && edge_n >= m_gedge + 3) m_busy = 0;
      if (!m_busy) begin
        found = 0;
        for (int i = 1; i <= N; i++) begin
          c = (m_last + i) % N;
          if (!found && (core_read[c] || core_write[c])) begin
            found  = 1;
            m_core = c;
          end
        end
        if (found) begin
          m_busy      = 1;
          m_gedge     = edge_n;
          m_wr        = core_write[m_core];
          m_addr      = core_addr[m_core*AW +: AW];
          m_data      = core_wdata[m_core*DW +: DW];
          m_addr_out  = m_addr;
          m_wdata_out = m_data;
          if (m_wr) mm[m_addr[7:0]] = m_data;
        end
      end
      if (START) begin
        m_endseen = '0;
        m_perr    = 0;
      end else begin
        m_endseen = m_endseen | core_end;
        if (|(core_read & core_write)) m_perr = 1;
      end
    end
  end

  // Per-cycle compare plus event logs for the directed scenarios.
  int            ack_log[$], ack_edge[$];
  bit            s_wr[$];
  logic [AW-1:0] s_addr[$];
  logic [DW-1:0] s_data[$];

  always @(negedge clk) begin
    if (chk_en) begin
      bit            strobe;
      logic [N-1:0]  eack;
      logic [N*DW-1:0] erd;
      strobe = m_busy && (edge_n == m_gedge);
      eack   = '0;
      if (m_busy && edge_n == m_gedge + 1) eack[m_core] = 1'b1;
      for (int k = 0; k < N; k++) erd[k*DW +: DW] = m_rdata[k];
      check("mem_read",     mem_read,     strobe && !m_wr);
      check("mem_write",    mem_write,    strobe && m_wr);
      check("mem_addr",     mem_addr,     m_addr_out);
      check("mem_wdata",    mem_wdata,    m_wdata_out);
      check("core_ack",     core_ack,     eack);
      check("core_rdata",   core_rdata,   erd);
      check("END",          END,          &m_endseen);
      check("protocol_err", protocol_err, m_perr);
      for (int k = 0; k < N; k++) begin
        if (core_ack[k]) begin
          ack_log.push_back(k);
          ack_edge.push_back(edge_n);
        end
      end
      if (mem_read || mem_write) begin
        s_wr.push_back(mem_write);
        s_addr.push_back(mem_addr);
        s_data.push_back(mem_wdata);
      end
    end
  end

  // Core agents: hold each request until acked, drop it on the edge ending the ack cycle.
  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } req_t;
  req_t         req_q [N][$];
  logic [N-1:0] active = '0;
  int           launch_edge [N];

  initial begin
    logic [N-1:0] acked;
    req_t         r;
    core_read = '0; core_write = '0; core_addr = '0; core_wdata = '0;
    forever begin
      @(negedge clk);
      acked = core_ack;
      @(posedge clk);
      #2;
      for (int k = 0; k < N; k++) begin
        if (!RESET) begin
          req_q[k].delete();
          active[k] = 1'b0; core_read[k] = 1'b0; core_write[k] = 1'b0;
        end else begin
          if (active[k] && acked[k]) begin
            active[k] = 1'b0; core_read[k] = 1'b0; core_write[k] = 1'b0;
          end
          if (!active[k] && req_q[k].size() > 0) begin
            r = req_q[k].pop_front();
            core_read[k]  = r.rd;
            core_write[k] = r.wr;
            core_addr[k*AW +: AW]  = r.a;
            core_wdata[k*DW +: DW] = r.d;
            active[k]      = 1'b1;
            launch_edge[k] = edge_n;
          end
        end
      end
    end
  end

  task automatic push(input int k, input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_t r;
    r.rd = rd; r.wr = wr; r.a = a; r.d = d;
    req_q[k].push_back(r);
  endtask

  function automatic bit pending();
    bit p = m_busy || (active != '0);
    for (int k = 0; k < N; k++) if (req_q[k].size() != 0) p = 1;
    return p;
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (pending() && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, n >= 200, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_end(input int k);
    @(posedge clk); #2;
    core_end = '0;
    core_end[k] = 1'b1;
    @(posedge clk); #2;
    core_end = '0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #2;
    START = 1'b1;
    @(posedge clk); #2;
    START = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, sb, n;
    core_end = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'h1000 + 16'(i);
      mm[i]  = 16'h1000 + 16'(i);
    end
    mem[16] = 16'hBEEF;
    mm[16]  = 16'hBEEF;

    #1 RESET = 1'b0;
    chk_en = 1;
    @(negedge clk);
    check("reset core_ack",   core_ack,   0);
    check("reset core_rdata", core_rdata, 0);
    check("reset mem_read",   mem_read,   0);
    check("reset mem_write",  mem_write,  0);
    check("reset END",        END,        0);
    @(negedge clk);
    RESET = 1'b1;

    // All four cores write at once: round-robin from core 0, one access every 3 cycles.
    b = ack_log.size(); sb = s_wr.size();
    for (int k = 0; k < N; k++) push(k, 1'b0, 1'b1, 16'h0020 + 16'(k), 16'hA000 + 16'(k));
    wait_idle("all-write timeout");
    check("all-write ack count", ack_log.size() - b, 4);
    check("all-write strobe count", s_wr.size() - sb, 4);
    for (int i = 0; i < 4; i++) begin
      check("all-write grant order", ack_log[b+i], i);
      check("all-write strobe is write", s_wr[sb+i], 1);
      check("all-write addr", s_addr[sb+i], 16'h0020 + 16'(i));
      check("all-write data", s_data[sb+i], 16'hA000 + 16'(i));
    end
    for (int i = 0; i < 3; i++) check("all-write spacing", ack_edge[b+i+1] - ack_edge[b+i], 3);

    // Core 2 reads 0x0010 holding 0xBEEF.
    b = ack_log.size(); sb = s_wr.size();
    push(2, 1'b1, 1'b0, 16'h0010, 16'h0000);
    wait_idle("read timeout");
    check("read strobe count", s_wr.size() - sb, 1);
    check("read strobe is read", s_wr[sb], 0);
    check("read addr", s_addr[sb], 16'h0010);
    check("read acked core", ack_log[b], 2);
    check("read ack latency", ack_edge[b] - launch_edge[2], 2);
    check("read rdata core2", core_rdata[2*DW +: DW], 16'hBEEF);

    // Read-back of data written earlier by core 1.
    push(0, 1'b1, 1'b0, 16'h0021, 16'h0000);
    wait_idle("readback timeout");
    check("readback rdata core0", core_rdata[0 +: DW], 16'hA001);

    // Core 1 keeps requesting while core 3 waits: strict alternation.
    b = ack_log.size();
    for (int i = 0; i < 3; i++) push(1, 1'b0, 1'b1, 16'h0040 + 16'(i), 16'h1100 + 16'(i));
    for (int i = 0; i < 2; i++) push(3, 1'b1, 1'b0, 16'h0010, 16'h0000);
    wait_idle("fairness timeout");
    check("fairness ack count", ack_log.size() - b, 5);
    for (int i = 0; i < 5; i++) check("fairness order", ack_log[b+i], (i % 2 == 0) ? 1 : 3);

    // Read and write together: write only, sticky error until START.
    sb = s_wr.size();
    push(0, 1'b1, 1'b1, 16'h0005, 16'h1234);
    wait_idle("rdwr timeout");
    check("rdwr strobe count", s_wr.size() - sb, 1);
    check("rdwr strobe is write", s_wr[sb], 1);
    check("rdwr addr", s_addr[sb], 16'h0005);
    check("rdwr data", s_data[sb], 16'h1234);
    check("rdwr protocol_err set", protocol_err, 1);
    pulse_start();
    check("rdwr protocol_err cleared", protocol_err, 0);

    // End flags in separate cycles; END one cycle after the last one.
    pulse_end(0);
    pulse_end(2);
    check("END after 0,2", END, 0);
    pulse_end(1);
    check("END after 0,2,1", END, 0);
    pulse_end(3);
    check("END after all", END, 1);
    pulse_start();
    check("END after START", END, 0);

    // Reset during ISSUE aborts the access without an ack.
    push(1, 1'b0, 1'b1, 16'h0030, 16'h5555);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_write && n < 20);
    check("abort wait timeout", n >= 20, 0);
    #1 RESET = 1'b0;
    #1;
    check("abort mem_write", mem_write, 0);
    check("abort mem_addr", mem_addr, 0);
    check("abort core_ack", core_ack, 0);
    check("abort core_rdata", core_rdata, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    RESET = 1'b1;
    b = ack_log.size(); sb = s_wr.size();
    repeat (4) @(negedge clk);
    check("abort no ack", ack_log.size() - b, 0);
    check("abort no strobe", s_wr.size() - sb, 0);
    push(2, 1'b0, 1'b1, 16'h0050, 16'h2222);
    push(1, 1'b0, 1'b1, 16'h0051, 16'h3333);
    push(0, 1'b0, 1'b1, 16'h0052, 16'h4444);
    wait_idle("post-reset timeout");
    check("post-reset first grant", ack_log[b], 0);
    check("post-reset second grant", ack_log[b+1], 1);
    check("post-reset third grant", ack_log[b+2], 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
